if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  IF stage: owns the PC, issues requests on a req/ack instruction bus and presents {pc, instruction} to the IF/ID register.
//  Resolves next-PC: sequential, branch redirect from ID, flush redirect from CTRL.
//  Raises stop_request while no instruction is available (memory wait states or a flush drain).
// PARAMETERS
//  ADDR_W    32            instruction address width
//  INST_W    32            instruction width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  PC_STEP   4             sequential increment, bytes
// PORTS
//  clock                  in   1       clock; all state updates on posedge
//  reset                  in   1       reset, synchronous, active-high
//  stop_all               in   6       CTRL stall bus; [0]=PC stage stop, [1]=IF stop
//  flush_input            in   1       exception flush; redirect to new_pc
//  new_pc                 in   ADDR_W  exception handler address
//  branch_flag            in   1       ID: branch/jump taken
//  branch_target_address  in   ADDR_W  ID: branch destination
//  imem_req               out  1       fetch request
//  imem_addr              out  ADDR_W  fetch address, word aligned
//  imem_ack               in   1       data valid this cycle; meaningful only while imem_req=1
//  imem_rdata             in   INST_W  fetched word
//  if_program_counter     out  ADDR_W  PC of presented instruction
//  if_instruction         out  INST_W  presented instruction
//  stop_request           out  1       to CTRL: IF cannot present a valid instruction
// BEHAVIOUR
//  Reset: state=S_RESET, pc=RESET_PC, imem_req=0, imem_addr=0, hold_buf=0, pending branch cleared,
//   if_program_counter=0, if_instruction=0, stop_request=1. Reset overrides every other input; an outstanding request is abandoned.
//  FSM (2-bit):
//   S_RESET: 1 cycle -> S_FETCH, imem_addr<=pc.
//   S_FETCH: imem_req=1, imem_addr held stable until imem_ack.
//   S_HOLD:  word captured but not consumed; imem_req=0.
//   S_DRAIN: flushed while a request is outstanding; keep req/old addr until ack, discard data.
//  present_valid = (S_FETCH & imem_ack) | S_HOLD.
//   if_instruction = S_HOLD ? hold_buf : imem_rdata.
//   if_program_counter = pc. Both 0 when !present_valid.
//  stop_request = !present_valid (combinational; no path from stop_all, so no loop).
//  consume = present_valid & (stop_all[0]==NoStop).
//   pc <= next_pc; imem_addr <= next_pc; state <= S_FETCH (back-to-back, 0-wait memory gives 1 instr/cycle).
//  S_FETCH & ack & !consume: hold_buf <= imem_rdata, state <= S_HOLD. In S_HOLD, consume -> S_FETCH.
//  next_pc priority: pending branch target > live branch_flag target > pc+PC_STEP (ADDR_W wrap, no carry out).
//  Branch: branch_flag without consume -> latch target, set pending; pending cleared on consume. Repeated flag overwrites target.
//  Flush (priority over all but reset): pc<=new_pc; pending and hold_buf cleared.
//   Request outstanding with no ack this cycle -> S_DRAIN.
//   Otherwise (ack same cycle, S_HOLD, idle) -> S_FETCH, imem_addr<=new_pc; the same-cycle ack word is discarded.
//  S_DRAIN: on ack -> S_FETCH, imem_addr<=pc. A second flush while draining updates pc only.
//  Branch during S_DRAIN ignored (a flush kills the younger branch).
// STRUCTURE
//  defines.v holds: ZeroWord, Stop/NoStop, StopAllBus, InstructionAddressBus, InstructionBus.
//   Add FetchStateBus and S_RESET/S_FETCH/S_HOLD/S_DRAIN encodings.
//  No sub-module: next-PC mux, FSM and hold buffer stay in one file.
// TESTING
//  1 Reset release, 0-wait mem (ack=req) -> pc 0x0,0x4,0x8 on consecutive cycles; stop_request=0 from cycle 2.
//  2 2 wait states at 0x0 -> stop_request=1 two cycles; imem_addr stays 0x0; then word presented, pc->0x4.
//  3 ack 0x24010001 while stop_all[0]=1 for 3 cycles -> S_HOLD, imem_req=0, same word/pc re-presented;
//    after release, next fetch 0x4.
//  4 branch_flag pulse, target 0x100, while mem busy at 0x8 -> 0x8 presented, next imem_addr=0x100.
//    Live branch at consume: same result.
//  5 flush new_pc=0x20 with 3-wait request at 0x10 -> req/addr 0x10 held until ack, data dropped,
//    stop_request=1 throughout, then fetch 0x20.
//  6 flush same cycle as ack -> word dropped, next addr 0x20.
//    Reset mid-wait -> imem_req=0 next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg
//   Shared types and constants for the instruction fetch (IF) stage.
//   fetch_state_e : IF request FSM encoding
//   STOP / NO_STOP: polarity of the CTRL stall bus bits
//   STOP_ALL_W    : width of the CTRL stall bus
//   STOP_PC_BIT   : stall bus bit that freezes the PC
package if_fetch_unit_pkg;

  localparam int STOP_ALL_W  = 6;
  localparam int STOP_PC_BIT = 0;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   IF stage: owns the PC, fetches over a req/ack instruction bus and presents
//   {pc, instruction} to the IF/ID register. Next PC is sequential, an ID branch
//   redirect, or a CTRL flush redirect.
// Ports
//   clock, reset           : clock, synchronous active-high reset
//   stop_all               : CTRL stall bus, [0] freezes the PC
//   flush_input, new_pc    : exception flush and handler address
//   branch_flag,
//   branch_target_address  : taken branch from ID and its destination
//   imem_req, imem_addr    : fetch request and word-aligned address
//   imem_ack, imem_rdata   : fetch response (ack valid only while imem_req)
//   if_program_counter,
//   if_instruction         : presented instruction, zero when none is valid
//   stop_request           : high while no instruction can be presented
//
// state   | meaning
// S_RESET | first cycle after reset, load imem_addr from pc
// S_FETCH | request outstanding, address stable until ack
// S_HOLD  | word captured but stalled, request dropped
// S_DRAIN | flushed with a request in flight, wait for ack and drop data
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [STOP_ALL_W-1:0] stop_all,
  input  logic                  flush_input,
  input  logic [ADDR_W-1:0]     new_pc,
  input  logic                  branch_flag,
  input  logic [ADDR_W-1:0]     branch_target_address,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_W-1:0]     imem_rdata,
  output logic [ADDR_W-1:0]     if_program_counter,
  output logic [INST_W-1:0]     if_instruction,
  output logic                  stop_request
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] hold_q, hold_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic              present_valid;
  logic              consume;
  logic [ADDR_W-1:0] next_pc;

  // Only the PC-stage stop bit matters here; the rest of the bus is for
  // other stages.
  logic unused_stop_bits;
  assign unused_stop_bits = ^stop_all[STOP_ALL_W-1:1];

  assign imem_req      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr     = addr_q;
  assign present_valid = ((state_q == S_FETCH) && imem_ack) || (state_q == S_HOLD);
  assign consume       = present_valid && (stop_all[STOP_PC_BIT] == NO_STOP);

  assign if_program_counter = present_valid ? pc_q : '0;
  assign if_instruction     = !present_valid      ? '0     :
                              (state_q == S_HOLD) ? hold_q : imem_rdata;
  assign stop_request       = !present_valid;

  // A branch seen while stalled outranks a live one: it is the older decision.
  assign next_pc = pend_q      ? tgt_q :
                   branch_flag ? branch_target_address :
                                 pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    if (flush_input) begin
      pc_d   = new_pc;
      pend_d = 1'b0;
      hold_d = '0;
      // An unanswered request cannot be retracted: wait it out on the old address.
      if (imem_req && !imem_ack) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
        addr_d  = new_pc;
      end
    end else begin
      unique case (state_q)
        S_RESET: begin
          state_d = S_FETCH;
          addr_d  = pc_q;
        end
        S_FETCH: begin
          if (imem_ack && !consume) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
        S_HOLD: state_d = S_HOLD;
        S_DRAIN: begin
          if (imem_ack) begin
            state_d = S_FETCH;
            addr_d  = pc_q;
          end
        end
        default: state_d = S_RESET;
      endcase
      if (consume) begin
        pc_d    = next_pc;
        addr_d  = next_pc;
        state_d = S_FETCH;
        pend_d  = 1'b0;
      end else if (branch_flag && (state_q != S_DRAIN)) begin
        pend_d = 1'b1;
        tgt_d  = branch_target_address;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule
